// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM state encoding, sequencer opcode constants and opcode field helper
package fetch_pkg;
  typedef logic [1:0] fstate_t;
  localparam fstate_t F_IDLE = 2'd0;
  localparam fstate_t F_REQ  = 2'd1;
  localparam fstate_t F_DONE = 2'd2;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 10;
  localparam logic [5:0] OP_HALT  = 6'd0;
  localparam logic [5:0] OP_CLAC  = 6'd1;
  localparam logic [5:0] OP_LDAC  = 6'd2;
  localparam logic [5:0] OP_STAC  = 6'd3;
  localparam logic [5:0] OP_MVACR = 6'd4;
  localparam logic [5:0] OP_MVRAC = 6'd5;
  localparam logic [5:0] OP_ADD   = 6'd6;
  localparam logic [5:0] OP_MUL   = 6'd7;
  function automatic logic [5:0] opcode_of(input logic [15:0] ir);
    return ir[OPCODE_MSB:OPCODE_LSB];
  endfunction
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts un-acked request cycles and flags expiry on the MAX_WAIT-th one
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : restart count (no request outstanding)
//   en_i         : request outstanding and not acked this cycle
//   expire_o     : this is the MAX_WAIT-th consecutive un-acked cycle
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + CW'(1);
  end
  assign expire_o = en_i && (cnt_q == CW'(MAX_WAIT - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and instruction fetcher feeding the sequencer over a mem req/ack port
//   clock, reset           : clock, synchronous active-high reset
//   fetch_req, pc_load(_val): fetch pulse and jump request/target from the sequencer
//   mem_req/addr/ack/rdata : instruction memory read handshake
//   IR, ir_valid, pc, busy : fetched instruction, its one-cycle strobe, program counter, demand busy
//   fetch_err              : sticky watchdog abort / overrun flag
// Build option PREFETCH_EN: adds a one-word background prefetch buffer at the next pc.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] IR,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_err
);
`ifdef PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif
  fstate_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, pend_q, pend_d, buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d, buf_q, buf_d;
  logic req_q, req_d, err_q, err_d, pend_v_q, pend_v_d, pf_q, pf_d, kill_q, kill_d;
  logic want_q, want_d, buf_v_q, buf_v_d;
  logic expire, pf_busy, dem_ack, dem_abort, hit, conv;
  fetch_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wd (
    .clk_i(clock), .rst_i(reset), .clr_i(!req_q), .en_i(req_q && !mem_ack), .expire_o(expire)
  );
  // pf_q marks the outstanding request as a prefetch; kill_q means its data is stale after a jump
  assign pf_busy   = req_q && pf_q;
  assign dem_ack   = state_q == F_REQ && req_q && !pf_q && mem_ack;
  assign dem_abort = state_q == F_REQ && req_q && !pf_q && expire;
  assign hit       = PF_EN && buf_v_q && buf_addr_q == pc_q && !pc_load;
  // an in-flight prefetch of the wanted address is adopted as the demand request
  assign conv      = pf_busy && !kill_q && !pc_load && addr_q == pc_q && !expire;
  always_comb begin
    state_d = state_q; pc_d = pc_q; addr_d = addr_q; pend_d = pend_q; buf_addr_d = buf_addr_q;
    ir_d = ir_q; buf_d = buf_q; req_d = req_q; err_d = err_q; pend_v_d = pend_v_q;
    pf_d = pf_q; kill_d = kill_q; want_d = want_q; buf_v_d = buf_v_q;
    if (fetch_req && state_q != F_IDLE) err_d = 1'b1;
    if (pc_load) buf_v_d = 1'b0;
    if (pf_busy && (mem_ack || expire)) begin
      req_d = 1'b0; pf_d = 1'b0; kill_d = 1'b0;
      if (mem_ack && !kill_q && !pc_load) begin
        buf_v_d = 1'b1; buf_addr_d = addr_q; buf_d = mem_rdata;
      end
    end else if (pf_busy && pc_load) kill_d = 1'b1;
    if (state_q == F_IDLE) begin
      if (pc_load) pc_d = pc_load_val;
      if (fetch_req) begin
        if (hit || (conv && mem_ack)) begin
          ir_d = hit ? buf_q : mem_rdata; pc_d = pc_q + ADDR_W'(1);
          buf_v_d = 1'b0; want_d = 1'b1; state_d = F_DONE;
        end else if (conv) begin
          pf_d = 1'b0; state_d = F_REQ;
        end else begin
          state_d = F_REQ;
          if (!pf_busy) begin
            req_d = 1'b1; addr_d = pc_load ? pc_load_val : pc_q;
          end
        end
      end
    end else if (state_q == F_REQ) begin
      // port was held by a stale prefetch: launch the demand read once it is free
      if (!req_q) begin
        req_d = 1'b1; addr_d = pc_q; pf_d = 1'b0;
      end
      if (dem_ack || dem_abort) begin
        req_d = 1'b0; state_d = F_DONE; pend_v_d = 1'b0; want_d = dem_ack;
        ir_d = dem_ack ? mem_rdata : '0;
        if (dem_abort) err_d = 1'b1;
        pc_d = pc_load ? pc_load_val : pend_v_q ? pend_q : dem_ack ? pc_q + ADDR_W'(1) : pc_q;
      end else if (pc_load) begin
        pend_v_d = 1'b1; pend_d = pc_load_val;
      end
    end else begin
      state_d = F_IDLE; want_d = 1'b0;
      if (pc_load) pc_d = pc_load_val;
      else if (PF_EN && want_q && !req_q) begin
        req_d = 1'b1; addr_d = pc_q; pf_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= F_IDLE; pc_q <= PC_RESET; addr_q <= '0; pend_q <= '0; buf_addr_q <= '0;
      ir_q <= '0; buf_q <= '0; req_q <= 1'b0; err_q <= 1'b0; pend_v_q <= 1'b0;
      pf_q <= 1'b0; kill_q <= 1'b0; want_q <= 1'b0; buf_v_q <= 1'b0;
    end else begin
      state_q <= state_d; pc_q <= pc_d; addr_q <= addr_d; pend_q <= pend_d; buf_addr_q <= buf_addr_d;
      ir_q <= ir_d; buf_q <= buf_d; req_q <= req_d; err_q <= err_d; pend_v_q <= pend_v_d;
      pf_q <= pf_d; kill_q <= kill_d; want_q <= want_d; buf_v_q <= buf_v_d;
    end
  end
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign IR        = ir_q;
  assign ir_valid  = state_q == F_DONE;
  assign pc        = pc_q;
  assign busy      = state_q == F_REQ;
  assign fetch_err = err_q;
endmodule
